mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge_pkg.sv | 40 ++++
 rtl/mem_bus_bridge_if.sv | 28 ++
 rtl/mem_bus_bridge_byte_lane_swap.sv | 21 ++
 rtl/mem_bus_bridge.sv | 130 +++++++++++++
 tb/tb_mem_bus_bridge.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// Shared types, widths and helpers for the mem-stage to SRAM-like bus bridge.
package mem_bus_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SZ_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [SZ_W-1:0] SIZE_B = 2'd0;
    localparam logic [SZ_W-1:0] SIZE_H = 2'd1;
    localparam logic [SZ_W-1:0] SIZE_W = 2'd2;

    // Request fields captured in IDLE and held for the whole bus transaction.
    typedef struct packed {
        logic              wr;
        logic [STRB_W-1:0] sel;
        logic [DATA_W-1:0] wdata;
    } req_fields_t;

    // Access size from the number of enabled byte lanes.
    function automatic logic [SZ_W-1:0] size_from_sel(input logic [STRB_W-1:0] sel);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            n = n + 3'(sel[i]);
        end
        case (n)
            3'd0, 3'd1: size_from_sel = SIZE_B;
            3'd2:       size_from_sel = SIZE_H;
            default:    size_from_sel = SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// SRAM-like request/response bus between the bridge (master) and memory (slave).
interface mem_bus_bridge_if
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);

    logic              req_o;
    logic              req_wr_o;
    logic [SZ_W-1:0]   req_size_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic [STRB_W-1:0] req_wstrb_o;
    logic [DATA_W-1:0] req_wdata_o;
    logic              addr_ok_i;
    logic              data_ok_i;
    logic [DATA_W-1:0] rdata_i;

    modport master (
        output req_o, req_wr_o, req_size_o, req_addr_o, req_wstrb_o, req_wdata_o,
        input  addr_ok_i, data_ok_i, rdata_i
    );

    modport slave (
        input  req_o, req_wr_o, req_size_o, req_addr_o, req_wstrb_o, req_wdata_o,
        output addr_ok_i, data_ok_i, rdata_i
    );

endinterface

// File: rtl/mem_bus_bridge_byte_lane_swap.sv
// Mirrors byte lanes (lane i <-> lane 3-i) of a data word and its strobe.
module byte_lane_swap
    import mem_bus_bridge_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [STRB_W-1:0] i_strb,
    output logic [DATA_W-1:0] o_data,
    output logic [STRB_W-1:0] o_strb
);

    // Reverse lane order for data bytes and strobe bits together.
    always_comb begin
        o_data = '0;
        o_strb = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            o_data[8*i +: 8] = i_data[8*(int'(STRB_W)-1-i) +: 8];
            o_strb[i]        = i_strb[int'(STRB_W)-1-i];
        end
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Turns one mem-stage load/store into an SRAM-like bus transaction, stalling
// the pipeline until the data phase completes; flushed accesses still finish
// on the bus but their result is dropped.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en_i,
    input  logic              mem_write_en_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [3:0]        mem_select_i,
    input  logic              flush_i,
    output logic [31:0]       ram_data_o,
    output logic              pause_o,
    mem_bus_bridge_if.master  bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_cancel;
    logic [ADDR_W-1:0] r_addr;
    req_fields_t       r_req;
    logic [DATA_W-1:0] r_rbuf;

    logic              w_start;
    logic              w_cancel;
    logic              w_capture;
    logic [DATA_W-1:0] w_wr_data;
    logic [STRB_W-1:0] w_wr_strb;
    logic [DATA_W-1:0] w_rd_data;
    logic [STRB_W-1:0] w_rd_lane;

    assign w_start   = ram_en_i & ~flush_i;
    assign w_cancel  = r_cancel | flush_i;
    assign w_capture = (r_state == DATA) & bus.data_ok_i & ~w_cancel;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; each handshake is only honoured in its own phase.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_start)         w_state_nxt = ADDR;
            ADDR: if (bus.addr_ok_i)   w_state_nxt = DATA;
            DATA: if (bus.data_ok_i)   w_state_nxt = w_cancel ? IDLE : DONE;
            DONE:                      w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Cancel flag: set by a flush while the bus is busy, cleared when back in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cancel <= 1'b0;
        end else if (w_state_nxt == IDLE) begin
            r_cancel <= 1'b0;
        end else if (((r_state == ADDR) || (r_state == DATA)) && flush_i) begin
            r_cancel <= 1'b1;
        end
    end

    // Latch the request fields when a new access is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_req  <= '0;
        end else if ((r_state == IDLE) && w_start) begin
            r_addr      <= ADDR_W'(mem_addr_i);
            r_req.wr    <= mem_write_en_i;
            r_req.sel   <= mem_select_i;
            r_req.wdata <= store_data_i;
        end
    end

    // Read buffer keeps the last non-cancelled response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rbuf <= '0;
        end else if (w_capture) begin
            r_rbuf <= bus.rdata_i;
        end
    end

    // Write path: bus-side lane order, strobes only for stores.
    byte_lane_swap u_wr_swap (
        .i_data (r_req.wdata),
        .i_strb (r_req.wr ? r_req.sel : STRB_W'(0)),
        .o_data (w_wr_data),
        .o_strb (w_wr_strb)
    );

    // Read path: back to mem-stage lane order; lane enables drop during reset.
    byte_lane_swap u_rd_swap (
        .i_data (r_rbuf),
        .i_strb ({STRB_W{rst}}),
        .o_data (w_rd_data),
        .o_strb (w_rd_lane)
    );

    // Outputs decoded from state and latched fields; reset forces the controls low.
    always_comb begin
        bus.req_o       = 1'b0;
        bus.req_wr_o    = r_req.wr;
        bus.req_size_o  = size_from_sel(r_req.sel);
        bus.req_addr_o  = r_addr;
        bus.req_wstrb_o = w_wr_strb;
        bus.req_wdata_o = w_wr_data;
        pause_o         = 1'b0;
        ram_data_o      = '0;
        if (rst) begin
            bus.req_o = (r_state == ADDR);
            pause_o   = w_start & (r_state != DONE);
        end
        for (int k = 0; k < int'(STRB_W); k++) begin
            ram_data_o[8*k +: 8] = w_rd_data[8*k +: 8] & {8{w_rd_lane[k]}};
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: table-driven transactions with a
// scoreboard plus hand-written flush/reset sequences.
module tb_mem_bus_bridge;

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  sel;
    logic        flush;
    logic [31:0] ram_data;
    logic        pause;

    mem_bus_bridge_if #(.ADDR_W(32)) bus_if ();

    mem_bus_bridge #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en_i       (ram_en),
        .mem_write_en_i (wr),
        .mem_addr_i     (addr),
        .store_data_i   (sdata),
        .mem_select_i   (sel),
        .flush_i        (flush),
        .ram_data_o     (ram_data),
        .pause_o        (pause),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        int          gap;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_rout;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rout;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[8];
    int          n_tests;
    int          n_fail;
    logic [31:0] last_rout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_mem(input logic en, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d, input logic f);
        ram_en = en; wr = w; addr = a; sel = s; sdata = d; flush = f;
    endtask

    task automatic drive_bus(input logic aok, input logic dok, input logic [31:0] rd);
        bus_if.addr_ok_i = aok;
        bus_if.data_ok_i = dok;
        bus_if.rdata_i   = rd;
    endtask

    // One full access; handshakes asserted outside their phase must be ignored.
    task automatic run_txn(input vec_t v);
        exp_t e;
        exp_t cur;
        cur = '{default: '0};
        for (int g = 0; g < v.gap; g++) begin
            @(negedge clk);
            drive_mem(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
            drive_bus(1'b1, 1'b1, 32'hBAD0_BAD0);
            #1;
            chk("idle_req", 32'(bus_if.req_o), 32'd0);
            chk("idle_pause", 32'(pause), 32'd0);
            chk("idle_hold", ram_data, last_rout);
        end
        // IDLE cycle: request presented
        @(negedge clk);
        drive_mem(1'b1, v.wr, v.addr, v.sel, v.sdata, 1'b0);
        drive_bus(1'b1, 1'b1, 32'hBAD1_BAD1);
        e.wr = v.wr; e.addr = v.addr; e.size = v.e_size;
        e.wstrb = v.e_wstrb; e.wdata = v.e_wdata; e.rout = v.e_rout;
        sb_q.push_back(e);
        #1;
        chk("start_pause", 32'(pause), 32'd1);
        chk("start_req", 32'(bus_if.req_o), 32'd0);
        chk("start_hold", ram_data, last_rout);
        // ADDR phase: mem-stage inputs scrambled to prove the fields are latched
        for (int w = 0; w <= v.aw; w++) begin
            @(negedge clk);
            drive_mem(1'b1, ~v.wr, ~v.addr, ~v.sel, ~v.sdata, 1'b0);
            drive_bus(w == v.aw, 1'b1, 32'hBAD2_BAD2);
            #1;
            if (w == 0) begin
                chk("sb_pending", 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) cur = sb_q.pop_front();
            end
            chk("addr_req", 32'(bus_if.req_o), 32'd1);
            chk("addr_pause", 32'(pause), 32'd1);
            chk("addr_wr", 32'(bus_if.req_wr_o), 32'(cur.wr));
            chk("addr_addr", bus_if.req_addr_o, cur.addr);
            chk("addr_size", 32'(bus_if.req_size_o), 32'(cur.size));
            chk("addr_wstrb", 32'(bus_if.req_wstrb_o), 32'(cur.wstrb));
            if (cur.wr) chk("addr_wdata", bus_if.req_wdata_o, cur.wdata);
        end
        // DATA phase
        for (int w = 0; w <= v.dw; w++) begin
            @(negedge clk);
            drive_bus(1'b1, w == v.dw, (w == v.dw) ? v.rdata : 32'hBAD3_BAD3);
            #1;
            chk("data_req", 32'(bus_if.req_o), 32'd0);
            chk("data_pause", 32'(pause), 32'd1);
        end
        // DONE cycle
        @(negedge clk);
        drive_mem(1'b1, v.wr, v.addr, v.sel, v.sdata, 1'b0);
        drive_bus(1'b1, 1'b1, 32'hBAD4_BAD4);
        #1;
        chk("done_pause", 32'(pause), 32'd0);
        chk("done_req", 32'(bus_if.req_o), 32'd0);
        chk("done_rdata", ram_data, cur.rout);
        last_rout = cur.rout;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        last_rout = 32'h0;

        //            wr    addr          sel      sdata         rdata         aw dw gap size  wstrb    wdata         rout
        vecs[0] = '{1'b0, 32'h1C00_0002, 4'b0010, 32'h0000_0000, 32'h00AB_0000, 0, 0, 1, 2'd0, 4'b0000, 32'h0,        32'h0000_AB00};
        vecs[1] = '{1'b1, 32'h1C00_0010, 4'b1100, 32'h1234_1234, 32'h0000_0000, 3, 0, 0, 2'd1, 4'b0011, 32'h3412_3412, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h1C00_0100, 4'b1111, 32'hFFFF_FFFF, 32'h1122_3344, 1, 2, 2, 2'd2, 4'b0000, 32'h0,        32'h4433_2211};
        vecs[3] = '{1'b0, 32'h1C00_0102, 4'b0011, 32'h0000_0000, 32'h0000_BEEF, 0, 1, 0, 2'd1, 4'b0000, 32'h0,        32'hEFBE_0000};
        vecs[4] = '{1'b1, 32'h1C00_0203, 4'b0001, 32'h5A5A_5A5A, 32'h0000_0000, 0, 0, 1, 2'd0, 4'b1000, 32'h5A5A_5A5A, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h1C00_0300, 4'b1111, 32'hA1B2_C3D4, 32'h0000_0000, 2, 1, 0, 2'd2, 4'b1111, 32'hD4C3_B2A1, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h1C00_0401, 4'b0100, 32'h0102_0304, 32'h0000_0000, 0, 0, 1, 2'd0, 4'b0010, 32'h0403_0201, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h1C00_0403, 4'b1000, 32'h0000_0000, 32'h0000_00C3, 0, 0, 0, 2'd0, 4'b0000, 32'h0,        32'hC300_0000};

        // Reset with a pending request: controls and read data stay low
        rst = 1'b0;
        drive_mem(1'b1, 1'b0, 32'h1C00_0000, 4'b1111, 32'h0, 1'b0);
        drive_bus(1'b1, 1'b1, 32'hFFFF_FFFF);
        #1;
        chk("rst_req", 32'(bus_if.req_o), 32'd0);
        chk("rst_pause", 32'(pause), 32'd0);
        chk("rst_rdata", ram_data, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req2", 32'(bus_if.req_o), 32'd0);
        chk("rst_pause2", 32'(pause), 32'd0);
        chk("rst_rdata2", ram_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_mem(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b0, 32'h0);

        // Table: loads/stores with varied waits, several back-to-back
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Flush in DATA: data_ok two cycles later, result dropped, no DONE
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 32'h1C00_0200, 4'b1111, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b0, 32'h0);
        #1; chk("fd_start_pause", 32'(pause), 32'd1);
        @(negedge clk);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1; chk("fd_addr_req", 32'(bus_if.req_o), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        drive_bus(1'b0, 1'b0, 32'h0);
        #1; chk("fd_flush_pause", 32'(pause), 32'd0);
        @(negedge clk);
        drive_mem(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        #1; chk("fd_wait_pause", 32'(pause), 32'd0);
        @(negedge clk);
        drive_bus(1'b0, 1'b1, 32'h9999_9999);
        #1;
        chk("fd_dok_pause", 32'(pause), 32'd0);
        chk("fd_dok_req", 32'(bus_if.req_o), 32'd0);
        run_txn(vecs[2]);

        // Flush in ADDR: req held until addr_ok, transaction completes, no DONE
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 32'h1C00_0500, 4'b1111, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b0, 32'h0);
        #1; chk("fa_start_pause", 32'(pause), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fa_flush_req", 32'(bus_if.req_o), 32'd1);
        chk("fa_flush_pause", 32'(pause), 32'd0);
        @(negedge clk);
        drive_mem(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        #1; chk("fa_wait_req", 32'(bus_if.req_o), 32'd1);
        @(negedge clk);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1; chk("fa_aok_req", 32'(bus_if.req_o), 32'd1);
        @(negedge clk);
        drive_bus(1'b0, 1'b1, 32'h7777_7777);
        #1; chk("fa_data_req", 32'(bus_if.req_o), 32'd0);
        run_txn(vecs[0]);

        // Reset in DATA abandons the access; the next load is unaffected
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 32'h1C00_0600, 4'b1111, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1; chk("rd_addr_req", 32'(bus_if.req_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        chk("rd_rst_pause", 32'(pause), 32'd0);
        chk("rd_rst_rdata", ram_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_mem(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        drive_bus(1'b0, 1'b1, 32'h5555_5555);
        #1;
        chk("rd_after_req", 32'(bus_if.req_o), 32'd0);
        chk("rd_after_pause", 32'(pause), 32'd0);
        chk("rd_after_rdata", ram_data, 32'd0);
        last_rout = 32'h0;
        run_txn(vecs[3]);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
